cla_seq_addsub: RTL and testbench

Multi-cycle add/subtract sequencer that streams WIDTH-bit operands through a single instance of the team's 4-bit carry-lookahead adder (cla_4bit), one nibble per clock, LSB nibble first. The block trades latency for area and owns the inter-nibble carry register, operand shifting, flag generation and a valid/ready handshake on both sides. It sits between the HP-AU operand registers and the result/flag writeback stage.

---
 rtl/hpau_pkg.sv | 17 +
 rtl/cla_4bit.sv | 31 +++
 rtl/cla_seq_addsub.sv | 136 +++++++++++++
 tb/tb_cla_seq_addsub.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hpau_pkg.sv
// Shared types and constants for the HP-AU nibble-serial add/subtract sequencer.
package hpau_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  // Legal operand widths: whole nibbles, at least two of them.
  function automatic bit width_ok(input int unsigned w);
    return ((w % NIBBLE) == 0) && (w >= 2 * NIBBLE);
  endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder with group propagate/generate outputs.
module cla_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_pg,
  output logic       o_gg
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_gg   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_pg   = &w_p;
  assign o_cout = o_gg | (o_pg & i_cin);
  assign o_sum  = w_p ^ w_c;

endmodule

// File: rtl/cla_seq_addsub.sv
// Nibble-serial add/subtract: one cla_4bit reused NIB times, LSB nibble first,
// with valid/ready handshakes on input and output.
module cla_seq_addsub
  import hpau_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NIB   = WIDTH / NIBBLE;
  localparam int unsigned CNT_W = $clog2(NIB);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("cla_seq_addsub: WIDTH must be a multiple of 4 and at least 8");
  end

  seq_state_e       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_cy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_zacc;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_b_in;
  logic [3:0]       w_sum;
  logic             w_cout;
  logic             w_sum_zero;
  logic             w_unused_pg;
  logic             w_unused_gg;

  // Subtraction is A + ~B + 1: invert B here, inject the +1 as the first carry-in.
  assign w_b_in     = op_sub ? ~op_b : op_b;
  assign w_sum_zero = (w_sum == 4'd0);

  cla_4bit u_cla (
    .i_a    (r_a_sh[NIBBLE-1:0]),
    .i_b    (r_b_sh[NIBBLE-1:0]),
    .i_cin  (r_cy),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_pg   (w_unused_pg),
    .o_gg   (w_unused_gg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_cy        <= 1'b0;
      r_cnt       <= '0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_zacc      <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh     <= op_a;
            r_b_sh     <= w_b_in;
            r_cy       <= op_sub;
            r_cnt      <= '0;
            r_a_msb    <= op_a[WIDTH-1];
            r_b_msb    <= w_b_in[WIDTH-1];
            r_zacc     <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_cy     <= w_cout;
          r_result <= {w_sum, r_result[WIDTH-1:NIBBLE]};
          r_a_sh   <= r_a_sh >> NIBBLE;
          r_b_sh   <= r_b_sh >> NIBBLE;
          r_zacc   <= r_zacc & w_sum_zero;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Top nibble: its carry and sign bit decide the flags.
          if (r_cnt == CNT_W'(NIB - 1)) begin
            r_carry     <= w_cout;
            r_zero      <= r_zacc & w_sum_zero;
            r_overflow  <= (r_a_msb == r_b_msb) & (w_sum[NIBBLE-1] != r_a_msb);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cla_seq_addsub.sv
// Directed bench for cla_seq_addsub: driver pushes expected results, monitor pops on handshake.
module tb_cla_seq_addsub;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry;
  logic        overflow;
  logic        zero;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  cla_seq_addsub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("carry", 32'(carry), 32'(e.c));
        chk("overflow", 32'(overflow), 32'(e.v));
        chk("zero", 32'(zero), 32'(e.z));
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] er, input logic ec, input logic ev,
                        input logic ez, input int hold);
    int          lat;
    logic [18:0] snap;
    @(negedge clk);
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    @(posedge clk);
    exp_q.push_back('{er, ec, ev, ez});
    #1;
    in_valid = 1'b0;
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
    op_sub   = 1'($urandom);
    lat = 1;
    while (!out_valid && lat <= 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd5);
    if (!out_valid) return;
    snap = {result, carry, overflow, zero};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op_a     = 16'hDEAD;
      op_b     = 16'hBEEF;
      op_sub   = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_stable", 32'({result, carry, overflow, zero}), 32'(snap));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after_retire", 32'(in_ready), 32'd1);
    chk("out_valid_after_retire", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({carry, overflow, zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0, 0);
    run_op(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    run_op(16'h5555, 16'h2AAA, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 6);

    // The operands pulsed during backpressure must not start a new operation.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("idle_no_phantom_valid", 32'(out_valid), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
    end

    // Abort an operation after two RUN cycles.
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = 16'h1111;
    op_b     = 16'h2222;
    op_sub   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);

    run_op(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
